uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 129 ++++++++++++
 tb/tb_uart_tx_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Byte scheduler in front of a UART transmitter: merges an echo byte stream and
// multi-byte ALU results onto one valid/ready byte channel with round-robin arbitration.
module uart_tx_sched #(
  parameter int RES_BYTES  = 4,
  parameter int ECHO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  echo_data_i,
  input  logic        echo_valid_i,
  output logic        echo_ready_o,
  input  logic [63:0] res_data_i,
  input  logic        res_valid_i,
  output logic        res_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o
);

  localparam int RW = 8 * RES_BYTES;
  localparam int PW = $clog2(ECHO_DEPTH);
  localparam int CW = $clog2(ECHO_DEPTH + 1);
  localparam int BW = $clog2(RES_BYTES + 1);

  typedef enum logic [1:0] {IDLE, ECHO, RES} state_t;

  state_t        state;
  logic [7:0]    mem [ECHO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [RW-1:0] res_q, res_shift;
  logic          res_full;
  logic [BW-1:0] byte_cnt;
  logic          last_grant;  // 1 = result unit was granted last

  logic push, pop, res_take, tx_fire, fifo_ne, grant_echo, grant_res, last_byte;

  always_comb begin
    fifo_ne    = (count != '0);
    push       = echo_valid_i && echo_ready_o;
    tx_fire    = tx_valid_o && tx_ready_i;
    // The echo byte stays in the FIFO until the transmitter takes it, so a
    // stalled transmitter leaves the full ECHO_DEPTH entries visible upstream.
    pop        = (state == ECHO) && tx_fire;
    res_take   = res_valid_i && !res_full;
    grant_echo = (state == IDLE) && fifo_ne && (!res_full || last_grant);
    grant_res  = (state == IDLE) && res_full && !grant_echo;
    last_byte  = (byte_cnt == BW'(RES_BYTES - 1));
    res_shift  = res_q >> 8;
  end

  assign echo_ready_o = (count != CW'(ECHO_DEPTH));
  assign res_ready_o  = !res_full;
  assign busy_o       = fifo_ne || res_full || tx_valid_o;

  // NOTE: the storage array has no reset; count and pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= echo_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      res_q      <= '0;
      res_full   <= 1'b0;
      byte_cnt   <= '0;
      last_grant <= 1'b1;
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else begin
      if (res_take) begin
        res_q    <= res_data_i[RW-1:0];
        res_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_echo) begin
            tx_data_o  <= mem[rd_ptr];
            tx_valid_o <= 1'b1;
            state      <= ECHO;
          end else if (grant_res) begin
            tx_data_o  <= res_q[7:0];
            tx_valid_o <= 1'b1;
            byte_cnt   <= '0;
            state      <= RES;
          end
        end
        ECHO: begin
          if (tx_fire) begin
            tx_valid_o <= 1'b0;
            last_grant <= 1'b0;
            state      <= IDLE;
          end
        end
        RES: begin
          if (tx_fire) begin
            if (byte_cnt != BW'(RES_BYTES)) byte_cnt <= byte_cnt + BW'(1);
            if (last_byte) begin
              tx_valid_o <= 1'b0;
              res_full   <= 1'b0;
              last_grant <= 1'b1;
              state      <= IDLE;
            end else begin
              // Shift the held word so the next byte is always at the bottom.
              tx_data_o <= res_shift[7:0];
              res_q     <= res_shift;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with default parameters
// (RES_BYTES=4, ECHO_DEPTH=4); bytes taken by the transmitter are logged in order.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  echo_data_i = 8'h00;
  logic        echo_valid_i = 1'b0;
  logic        echo_ready_o;
  logic [63:0] res_data_i = 64'h0;
  logic        res_valid_i = 1'b0;
  logic        res_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] got [$];

  uart_tx_sched dut (
    .clk(clk), .rst(rst),
    .echo_data_i(echo_data_i), .echo_valid_i(echo_valid_i), .echo_ready_o(echo_ready_o),
    .res_data_i(res_data_i), .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so a handshake seen at negedge fires on the next posedge.
  always @(negedge clk) if (rst && tx_valid_o && tx_ready_i) got.push_back(tx_data_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] got_packed();
    logic [63:0] v = '0;
    foreach (got[i]) v = {v[55:0], got[i]};
    return v;
  endfunction

  task automatic do_reset();
    echo_valid_i = 1'b0;
    res_valid_i  = 1'b0;
    tx_ready_i   = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    got.delete();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 60) begin
      tick();
      n++;
    end
    total++;
    if (busy_o) begin
      bad++;
      $display("FAIL %s_drain: busy still %b after %0d cycles, want 0", name, busy_o, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if ({tx_valid_o, tx_data_o, busy_o, echo_ready_o, res_ready_o} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h busy=%b er=%b rr=%b, want v=0 d=00 busy=0 er=1 rr=1",
               tx_valid_o, tx_data_o, busy_o, echo_ready_o, res_ready_o);
    end
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_echo();
    do_reset();
    tx_ready_i   = 1'b1;
    echo_valid_i = 1'b1;
    echo_data_i  = 8'h41;
    tick();
    echo_data_i = 8'h42;
    total++;
    if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL echo_pre_grant: valid %b want 0", tx_valid_o); end
    tick();
    echo_valid_i = 1'b0;
    total++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h41) begin
      bad++; $display("FAIL echo_first: valid %b data %h want 1 41", tx_valid_o, tx_data_o);
    end
    tick();
    total++;
    if (tx_valid_o !== 1'b0) begin bad++; $display("FAIL echo_gap: valid %b want 0", tx_valid_o); end
    tick();
    total++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h42) begin
      bad++; $display("FAIL echo_second: valid %b data %h want 1 42", tx_valid_o, tx_data_o);
    end
    wait_idle("echo");
    total++;
    if (got.size() != 2 || got_packed() !== 64'h4142) begin
      bad++; $display("FAIL echo_order: %0d bytes %h want 2 bytes 4142", got.size(), got_packed());
    end
  endtask

  task automatic test_result();
    logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    tx_ready_i  = 1'b1;
    res_data_i  = 64'h0000_0000_DEAD_BEEF;
    res_valid_i = 1'b1;
    tick();
    res_data_i = 64'h0000_0000_0000_1234;
    total++;
    if (res_ready_o !== 1'b0) begin bad++; $display("FAIL res_ready_held: got %b want 0", res_ready_o); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== exp_b[i] || res_ready_o !== 1'b0) begin
        bad++;
        $display("FAIL res_byte%0d: valid %b data %h rr %b want 1 %h 0", i, tx_valid_o, tx_data_o, res_ready_o, exp_b[i]);
      end
    end
    tick();
    total++;
    if (tx_valid_o !== 1'b0 || res_ready_o !== 1'b1) begin
      bad++; $display("FAIL res_release: valid %b rr %b want 0 1", tx_valid_o, res_ready_o);
    end
    tick();
    res_valid_i = 1'b0;
    total++;
    if (res_ready_o !== 1'b0) begin bad++; $display("FAIL res_second_capture: rr %b want 0", res_ready_o); end
    wait_idle("result");
    total++;
    if (got.size() != 8 || got_packed() !== 64'hEFBE_ADDE_3412_0000) begin
      bad++; $display("FAIL res_order: %0d bytes %h want 8 bytes efbeadde34120000", got.size(), got_packed());
    end
  endtask

  task automatic test_arbitration();
    do_reset();
    tx_ready_i   = 1'b1;
    echo_valid_i = 1'b1;
    echo_data_i  = 8'h55;
    res_data_i   = 64'h0000_0000_CAFE_F00D;
    res_valid_i  = 1'b1;
    tick();
    res_valid_i = 1'b0;
    echo_data_i = 8'h56;
    tick();
    echo_valid_i = 1'b0;
    wait_idle("arb");
    total++;
    if (got.size() != 6 || got_packed() !== 64'h0000_550D_F0FE_CA56) begin
      bad++; $display("FAIL arb_round_robin: %0d bytes %h want 6 bytes 550df0feca56", got.size(), got_packed());
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      echo_valid_i = 1'b1;
      echo_data_i  = 8'hA0 + 8'(i);
      tick();
      total++;
      if (echo_ready_o !== (i < 3)) begin
        bad++; $display("FAIL bp_ready_after_push%0d: got %b want %b", i + 1, echo_ready_o, (i < 3));
      end
    end
    echo_data_i = 8'hA4;
    repeat (3) tick();
    total++;
    if (echo_ready_o !== 1'b0 || tx_valid_o !== 1'b1 || tx_data_o !== 8'hA0) begin
      bad++; $display("FAIL bp_stall: er %b valid %b data %h want 0 1 a0", echo_ready_o, tx_valid_o, tx_data_o);
    end
    tx_ready_i = 1'b1;
    while (!echo_ready_o && n < 20) begin
      tick();
      n++;
    end
    tick();
    echo_valid_i = 1'b0;
    total++;
    if (n >= 20) begin bad++; $display("FAIL bp_ready_return: waited %0d cycles, want < 20", n); end
    wait_idle("bp");
    total++;
    if (got.size() != 5 || got_packed() !== 64'h0000_00A0_A1A2_A3A4) begin
      bad++; $display("FAIL bp_order: %0d bytes %h want 5 bytes a0a1a2a3a4", got.size(), got_packed());
    end
  endtask

  task automatic test_hold();
    logic stable = 1'b1;
    do_reset();
    res_data_i  = 64'h0000_0000_DEAD_BEEF;
    res_valid_i = 1'b1;
    tick();
    res_valid_i = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hEF) stable = 1'b0;
      tick();
    end
    total++;
    if (stable !== 1'b1 || got.size() != 0) begin
      bad++; $display("FAIL hold_stable: stable %b accepted %0d want 1 0 (data %h)", stable, got.size(), tx_data_o);
    end
    tx_ready_i = 1'b1;
    tick();
    total++;
    if (tx_data_o !== 8'hBE) begin bad++; $display("FAIL hold_advance: data %h want be", tx_data_o); end
    wait_idle("hold");
    total++;
    if (got.size() != 4 || got_packed() !== 64'hEFBE_ADDE) begin
      bad++; $display("FAIL hold_once: %0d bytes %h want 4 bytes efbeadde", got.size(), got_packed());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tx_ready_i  = 1'b1;
    res_data_i  = 64'h0000_0000_DEAD_BEEF;
    res_valid_i = 1'b1;
    tick();
    res_valid_i  = 1'b0;
    echo_valid_i = 1'b1;
    echo_data_i  = 8'h77;
    tick();
    echo_valid_i = 1'b0;
    tick();
    total++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== 8'hBE) begin
      bad++; $display("FAIL mid_setup: valid %b data %h want 1 be", tx_valid_o, tx_data_o);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({tx_valid_o, busy_o, echo_ready_o, res_ready_o} !== 4'b0011) begin
      bad++; $display("FAIL mid_reset_async: valid %b busy %b er %b rr %b want 0 0 1 1",
                      tx_valid_o, busy_o, echo_ready_o, res_ready_o);
    end
    tick();
    got.delete();
    rst          = 1'b1;
    echo_valid_i = 1'b1;
    echo_data_i  = 8'h99;
    tick();
    echo_valid_i = 1'b0;
    total++;
    if (busy_o !== 1'b1 || tx_valid_o !== 1'b0) begin
      bad++; $display("FAIL mid_first_push: busy %b valid %b want 1 0", busy_o, tx_valid_o);
    end
    wait_idle("mid");
    total++;
    if (got.size() != 1 || got_packed() !== 64'h99) begin
      bad++; $display("FAIL mid_no_stale: %0d bytes %h want 1 byte 99", got.size(), got_packed());
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_result();
    test_arbitration();
    test_backpressure();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
